// File: rtl/itch_decode_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : itch_decode_scheduler
// Brief    : Buffers ITCH payloads and dispatches each one to its per-type
//            decoder, with a decode timeout and drop/timeout statistics.
// Revision : 1.0 - initial release
// ============================================================================
module itch_decode_scheduler #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [511:0] in_payload,
    output logic [511:0] dec_payload,
    output logic [3:0]   dec_valid,
    input  logic [3:0]   dec_decoded,
    output logic         busy,
    output logic         done,
    output logic         timeout,
    output logic [1:0]   active_sel,
    output logic [15:0]  drop_count,
    output logic [15:0]  timeout_count
);

    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_TW = $clog2(TIMEOUT);
    localparam logic [c_AW:0]   c_FULL      = FIFO_DEPTH[c_AW:0];
    localparam logic [c_TW-1:0] c_WAIT_LAST = c_TW'(TIMEOUT - 1);

    localparam logic [7:0] c_TYPE_ADD    = 8'h41;
    localparam logic [7:0] c_TYPE_CANCEL = 8'h58;
    localparam logic [7:0] c_TYPE_EXEC   = 8'h45;
    localparam logic [7:0] c_TYPE_DELETE = 8'h44;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t          r_state;
    logic [511:0]    r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic [c_TW-1:0] r_wait_cnt;
    logic [511:0]    r_dec_payload;
    logic [3:0]      r_dec_valid;
    logic            r_done;
    logic            r_timeout;
    logic [1:0]      r_active_sel;
    logic [15:0]     r_drop_count;
    logic [15:0]     r_timeout_count;

    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic [511:0]    w_head;
    logic            w_known;
    logic [1:0]      w_sel;

    assign w_full   = (r_count == c_FULL);
    assign w_empty  = (r_count == '0);
    assign w_push   = in_valid && !w_full;
    assign w_pop    = (r_state == ST_IDLE) && !w_empty;
    assign w_head   = r_mem[r_rd_ptr];

    always_comb begin
        w_known = 1'b1;
        w_sel   = 2'd0;
        case (w_head[511:504])
            c_TYPE_ADD:    w_sel = 2'd0;
            c_TYPE_CANCEL: w_sel = 2'd1;
            c_TYPE_EXEC:   w_sel = 2'd2;
            c_TYPE_DELETE: w_sel = 2'd3;
            default:       w_known = 1'b0;
        endcase
    end

    // Storage carries no reset; the pointers alone define what is buffered.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_payload;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= ST_IDLE;
            r_wait_cnt      <= '0;
            r_dec_payload   <= '0;
            r_dec_valid     <= '0;
            r_done          <= 1'b0;
            r_timeout       <= 1'b0;
            r_active_sel    <= 2'd0;
            r_drop_count    <= '0;
            r_timeout_count <= '0;
        end else begin
            r_dec_valid <= '0;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_dec_payload <= w_head;
                        if (w_known) begin
                            r_active_sel <= w_sel;
                            r_dec_valid  <= 4'b0001 << w_sel;
                            r_state      <= ST_ISSUE;
                        end else if (r_drop_count != 16'hFFFF) begin
                            r_drop_count <= r_drop_count + 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    r_wait_cnt <= '0;
                    r_state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A decoded pulse on the final wait cycle still counts as done.
                    if (dec_decoded[r_active_sel]) begin
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end else if (r_wait_cnt == c_WAIT_LAST) begin
                        r_timeout <= 1'b1;
                        if (r_timeout_count != 16'hFFFF) begin
                            r_timeout_count <= r_timeout_count + 1'b1;
                        end
                        r_state <= ST_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready      = !w_full;
    assign busy          = (r_state != ST_IDLE) || !w_empty;
    assign dec_payload   = r_dec_payload;
    assign dec_valid     = r_dec_valid;
    assign done          = r_done;
    assign timeout       = r_timeout;
    assign active_sel    = r_active_sel;
    assign drop_count    = r_drop_count;
    assign timeout_count = r_timeout_count;

endmodule
`default_nettype wire

// File: tb/tb_itch_decode_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_itch_decode_scheduler
// Brief    : Self-checking bench: vector table, timing sequences and a
//            randomized run against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_itch_decode_scheduler;

    localparam int FIFO_DEPTH = 4;
    localparam int TIMEOUT    = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [511:0] in_payload = '0;
    logic [511:0] dec_payload;
    logic [3:0]   dec_valid;
    logic [3:0]   dec_decoded = '0;
    logic         busy;
    logic         done;
    logic         timeout;
    logic [1:0]   active_sel;
    logic [15:0]  drop_count;
    logic [15:0]  timeout_count;

    always #5 clk = ~clk;

    itch_decode_scheduler #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_payload    (in_payload),
        .dec_payload   (dec_payload),
        .dec_valid     (dec_valid),
        .dec_decoded   (dec_decoded),
        .busy          (busy),
        .done          (done),
        .timeout       (timeout),
        .active_sel    (active_sel),
        .drop_count    (drop_count),
        .timeout_count (timeout_count)
    );

    int checks = 0;
    int passed = 0;

    // Monitor / decoder model state: written only by the negedge process.
    logic [1:0]   mon_sel_q[$];
    logic [511:0] mon_pay_q[$];
    int           mon_issues = 0;
    int           mon_done = 0;
    int           mon_to = 0;
    int           mon_bad = 0;
    logic         prev_valid = 1'b0;
    int           rcnt[4];
    logic [1:0]   cur_sel = 2'd0;

    // Written by the stimulus process: decoder latency per issued message
    // (0 = never answers), and noise enable on non-active decoded bits.
    int           lat_by_issue[4096];
    bit           noise_en = 1'b0;

    always @(negedge clk) begin
        logic [3:0] dd;
        logic [1:0] sel;
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) rcnt[i] = 0;
            prev_valid  = 1'b0;
            dec_decoded = '0;
        end else begin
            dd = '0;
            for (int i = 0; i < 4; i++) begin
                if (rcnt[i] == 1) dd[i] = 1'b1;
                if (rcnt[i] != 0) rcnt[i] = rcnt[i] - 1;
                if (noise_en && (i != int'(cur_sel)) && ($urandom_range(0, 3) == 0)) dd[i] = 1'b1;
            end
            if (dec_valid != 4'b0000) begin
                sel = 2'd0;
                for (int i = 0; i < 4; i++) if (dec_valid[i]) sel = 2'(i);
                if (!$onehot(dec_valid) || prev_valid || (active_sel != sel)) mon_bad++;
                rcnt[sel] = lat_by_issue[mon_issues];
                cur_sel = sel;
                mon_sel_q.push_back(sel);
                mon_pay_q.push_back(dec_payload);
                mon_issues++;
            end
            prev_valid = |dec_valid;
            if (done) mon_done++;
            if (timeout) mon_to++;
            if (done && timeout) mon_bad++;
            dec_decoded = dd;
        end
    end

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [511:0] mk(input logic [7:0] t);
        logic [511:0] p;
        for (int i = 0; i < 16; i++) p[i*32 +: 32] = $urandom;
        p[511:504] = t;
        return p;
    endfunction

    // Reference classification straight from the message-type table.
    function automatic int type_sel(input logic [7:0] t);
        case (t)
            8'h41:   return 0;
            8'h58:   return 1;
            8'h45:   return 2;
            8'h44:   return 3;
            default: return -1;
        endcase
    endfunction

    task automatic push(input logic [511:0] p);
        int n = 0;
        in_valid   = 1'b1;
        in_payload = p;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        if (!in_ready) chk("push_wait_ready", 512'(in_ready), 512'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (busy && n < 300) begin
            tick();
            n++;
        end
        if (busy) chk("drain_idle", 512'(busy), 512'd0);
        @(negedge clk);
        #1;
    endtask

    typedef struct {
        logic [7:0] typ;
        int         lat;
        logic [3:0] exp_valid;
        logic [1:0] exp_sel;
        int         exp_done;
        int         exp_to;
        int         exp_drop;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int           i0, d0, t0;
        logic [15:0]  dc0, tc0;
        logic [511:0] p;
        logic [511:0] pb[6];
        logic [3:0]   exp_dv;
        logic         exp_pulse;
        int           exp_n_done, exp_n_to, exp_n_drop, base;
        logic [1:0]   exp_sel_q[$];
        logic [511:0] exp_pay_q[$];

        vecs[0] = '{8'h58, 1, 4'b0010, 2'd1, 1, 0, 0};
        vecs[1] = '{8'h41, 1, 4'b0001, 2'd0, 1, 0, 0};
        vecs[2] = '{8'h45, 3, 4'b0100, 2'd2, 1, 0, 0};
        vecs[3] = '{8'h44, 8, 4'b1000, 2'd3, 1, 0, 0};
        vecs[4] = '{8'h41, 9, 4'b0001, 2'd0, 0, 1, 0};
        vecs[5] = '{8'h44, 0, 4'b1000, 2'd3, 0, 1, 0};
        vecs[6] = '{8'h5A, 1, 4'b0000, 2'd3, 0, 0, 1};
        vecs[7] = '{8'h00, 1, 4'b0000, 2'd3, 0, 0, 1};
        vecs[8] = '{8'h61, 1, 4'b0000, 2'd3, 0, 0, 1};
        for (int i = 0; i < 4096; i++) lat_by_issue[i] = 1;

        // Reset state
        rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_in_ready", 512'(in_ready), 512'd1);
        chk("rst_busy", 512'(busy), 512'd0);
        rst_n = 1'b1;
        tick();
        chk("rst_dec_valid", 512'(dec_valid), 512'd0);
        chk("rst_done", 512'(done), 512'd0);
        chk("rst_timeout", 512'(timeout), 512'd0);
        chk("rst_active_sel", 512'(active_sel), 512'd0);
        chk("rst_drop_count", 512'(drop_count), 512'd0);
        chk("rst_timeout_count", 512'(timeout_count), 512'd0);
        chk("rst_dec_payload", dec_payload, 512'd0);
        chk("rst_in_ready_after", 512'(in_ready), 512'd1);

        // Single-message vector table
        foreach (vecs[v]) begin
            i0 = mon_issues; d0 = mon_done; t0 = mon_to;
            dc0 = drop_count; tc0 = timeout_count;
            lat_by_issue[i0] = vecs[v].lat;
            p = mk(vecs[v].typ);
            push(p);
            drain();
            chk($sformatf("vec%0d_issues", v), 512'(mon_issues - i0), 512'(vecs[v].exp_valid != 4'b0000));
            if (vecs[v].exp_valid != 4'b0000 && mon_issues > i0) begin
                exp_dv = 4'b0001 << mon_sel_q[i0];
                chk($sformatf("vec%0d_valid_bit", v), 512'(exp_dv), 512'(vecs[v].exp_valid));
                chk($sformatf("vec%0d_issue_payload", v), mon_pay_q[i0], p);
            end
            chk($sformatf("vec%0d_done", v), 512'(mon_done - d0), 512'(vecs[v].exp_done));
            chk($sformatf("vec%0d_timeout", v), 512'(mon_to - t0), 512'(vecs[v].exp_to));
            chk($sformatf("vec%0d_drop_count", v), 512'(drop_count - dc0), 512'(vecs[v].exp_drop));
            chk($sformatf("vec%0d_timeout_count", v), 512'(timeout_count - tc0), 512'(vecs[v].exp_to));
            chk($sformatf("vec%0d_active_sel", v), 512'(active_sel), 512'(vecs[v].exp_sel));
            chk($sformatf("vec%0d_dec_payload", v), dec_payload, p);
        end

        // End-to-end timing for one 'X' message
        lat_by_issue[mon_issues] = 1;
        p = mk(8'h58);
        in_valid = 1'b1; in_payload = p;
        tick();
        in_valid = 1'b0;
        chk("x_t0_valid", 512'(dec_valid), 512'd0);
        tick();
        chk("x_t1_valid", 512'(dec_valid), 512'h2);
        chk("x_t1_sel", 512'(active_sel), 512'd1);
        tick();
        chk("x_t2_valid", 512'(dec_valid), 512'd0);
        chk("x_t2_done", 512'(done), 512'd0);
        tick();
        chk("x_t3_done", 512'(done), 512'd1);
        tick();
        chk("x_t4_done", 512'(done), 512'd0);
        drain();

        // Back-to-back A, E, D with in_valid held
        pb[0] = mk(8'h41); pb[1] = mk(8'h45); pb[2] = mk(8'h44);
        for (int t = 0; t < 12; t++) begin
            in_valid = (t < 3);
            if (t < 3) in_payload = pb[t];
            tick();
            exp_dv = (t == 1) ? 4'b0001 : (t == 4) ? 4'b0100 : (t == 7) ? 4'b1000 : 4'b0000;
            exp_pulse = (t == 3) || (t == 6) || (t == 9);
            chk($sformatf("b2b_t%0d_valid", t), 512'(dec_valid), 512'(exp_dv));
            chk($sformatf("b2b_t%0d_done", t), 512'(done), 512'(exp_pulse));
            chk($sformatf("b2b_t%0d_ready", t), 512'(in_ready), 512'd1);
        end
        in_valid = 1'b0;
        drain();

        // Unknown type followed by 'X'
        dc0 = drop_count;
        pb[0] = mk(8'h5A); pb[1] = mk(8'h58);
        for (int t = 0; t < 4; t++) begin
            in_valid = (t < 2);
            if (t < 2) in_payload = pb[t];
            tick();
            exp_dv = (t == 2) ? 4'b0010 : 4'b0000;
            chk($sformatf("drop_t%0d_valid", t), 512'(dec_valid), 512'(exp_dv));
        end
        in_valid = 1'b0;
        drain();
        chk("drop_count_inc", 512'(drop_count - dc0), 512'd1);

        // Stalled 'A' times out, then 'E' is serviced
        tc0 = timeout_count;
        lat_by_issue[mon_issues] = 0;
        lat_by_issue[mon_issues + 1] = 1;
        pb[0] = mk(8'h41); pb[1] = mk(8'h45);
        for (int t = 0; t < 13; t++) begin
            in_valid = (t < 2);
            if (t < 2) in_payload = pb[t];
            tick();
            exp_dv = (t == 1) ? 4'b0001 : (t == 11) ? 4'b0100 : 4'b0000;
            chk($sformatf("to_t%0d_valid", t), 512'(dec_valid), 512'(exp_dv));
            chk($sformatf("to_t%0d_timeout", t), 512'(timeout), 512'(t == 10));
        end
        in_valid = 1'b0;
        drain();
        chk("to_count_inc", 512'(timeout_count - tc0), 512'd1);

        // Fill the FIFO while every decoder is stalled
        i0 = mon_issues; t0 = mon_to;
        for (int k = 0; k < 6; k++) begin
            lat_by_issue[i0 + k] = 0;
            pb[k] = mk((k % 2 == 0) ? 8'h41 : 8'h44);
        end
        for (int k = 0; k < 5; k++) push(pb[k]);
        chk("fill_full_ready", 512'(in_ready), 512'd0);
        push(pb[5]);
        drain();
        chk("fill_issues", 512'(mon_issues - i0), 512'd6);
        chk("fill_timeouts", 512'(mon_to - t0), 512'd6);
        for (int k = 0; k < 6; k++) begin
            if (mon_issues > i0 + k) chk($sformatf("fill_order%0d", k), mon_pay_q[i0 + k], pb[k]);
        end
        chk("fill_ready_end", 512'(in_ready), 512'd1);

        // Reset while waiting with two entries buffered
        for (int k = 0; k < 3; k++) lat_by_issue[mon_issues + k] = 0;
        push(mk(8'h41));
        push(mk(8'h58));
        push(mk(8'h45));
        chk("rstw_busy_before", 512'(busy), 512'd1);
        rst_n = 1'b0;
        #1;
        chk("rstw_dec_valid", 512'(dec_valid), 512'd0);
        chk("rstw_busy", 512'(busy), 512'd0);
        chk("rstw_drop_count", 512'(drop_count), 512'd0);
        chk("rstw_timeout_count", 512'(timeout_count), 512'd0);
        chk("rstw_in_ready", 512'(in_ready), 512'd1);
        chk("rstw_dec_payload", dec_payload, 512'd0);
        tick();
        rst_n = 1'b1;
        i0 = mon_issues; t0 = mon_to; d0 = mon_done;
        repeat (20) tick();
        chk("rstw_no_stale_issue", 512'(mon_issues - i0), 512'd0);
        chk("rstw_no_stale_pulse", 512'((mon_to - t0) + (mon_done - d0)), 512'd0);
        chk("rstw_busy_after", 512'(busy), 512'd0);

        // Randomized traffic against the transaction-level model
        noise_en = 1'b1;
        base = mon_issues; d0 = mon_done; t0 = mon_to;
        dc0 = drop_count; tc0 = timeout_count;
        exp_n_done = 0; exp_n_to = 0; exp_n_drop = 0;
        for (int m = 0; m < 60; m++) begin
            logic [7:0] t;
            int         lat;
            case ($urandom_range(0, 9))
                0:       t = 8'h5A;
                1:       t = 8'($urandom_range(0, 255));
                2, 3:    t = 8'h41;
                4, 5:    t = 8'h58;
                6, 7:    t = 8'h45;
                default: t = 8'h44;
            endcase
            p = mk(t);
            if (type_sel(t) >= 0) begin
                lat = $urandom_range(0, TIMEOUT + 2);
                lat_by_issue[base + exp_sel_q.size()] = lat;
                exp_sel_q.push_back(2'(type_sel(t)));
                exp_pay_q.push_back(p);
                if (lat >= 1 && lat <= TIMEOUT) exp_n_done++;
                else exp_n_to++;
            end else begin
                exp_n_drop++;
            end
            push(p);
            repeat ($urandom_range(0, 3)) tick();
        end
        drain();
        repeat (3) tick();
        noise_en = 1'b0;
        chk("rand_issues", 512'(mon_issues - base), 512'(exp_sel_q.size()));
        for (int k = 0; k < exp_sel_q.size(); k++) begin
            if (mon_issues > base + k) begin
                chk($sformatf("rand_sel%0d", k), 512'(mon_sel_q[base + k]), 512'(exp_sel_q[k]));
                chk($sformatf("rand_pay%0d", k), mon_pay_q[base + k], exp_pay_q[k]);
            end
        end
        chk("rand_done", 512'(mon_done - d0), 512'(exp_n_done));
        chk("rand_timeouts", 512'(mon_to - t0), 512'(exp_n_to));
        chk("rand_drop_count", 512'(drop_count - dc0), 512'(exp_n_drop));
        chk("rand_timeout_count", 512'(timeout_count - tc0), 512'(exp_n_to));
        chk("protocol_violations", 512'(mon_bad), 512'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
